// File: rtl/memory_sp_ctrl.sv
// memory_sp_ctrl: initiator-side controller for a single-port synchronous SRAM.
//   Request channel  : req_valid/req_ready, req_write, req_addr, req_wem, req_din
//   Response channel : rsp_valid/rsp_ready, rsp_dout, rsp_err (3-entry response FIFO)
//   Memory side      : mem_en, mem_we, mem_wem, mem_addr, mem_din, mem_dout (1-cycle read latency)
//   Status           : init_done (zero-fill finished, sticky until reset)
//   clk, nreset      : single clock, asynchronous active-low reset
module memory_sp_ctrl #(
    parameter int DW    = 104,
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH),
    parameter int INIT  = 1
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_write,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wem,
    input  logic [DW-1:0] req_din,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_dout,
    output logic          rsp_err,
    output logic          init_done,
    output logic          mem_en,
    output logic          mem_we,
    output logic [DW-1:0] mem_wem,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout
);
    typedef enum logic {S_INIT, S_RUN} state_t;

    localparam logic [AW:0]   LIM  = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    state_t        state, state_nxt;
    logic [AW-1:0] cnt;
    logic          pend, pend_err;
    logic [DW:0]   fifo [3];
    logic [1:0]    wptr, rptr, count;
    logic          acc, in_range, last, push, pop, head_err;

    assign last     = (state == S_INIT) && (cnt == LAST);
    assign in_range = {1'b0, req_addr} < LIM;
    // Credits: every read in flight (pending or buffered) owns a FIFO slot.
    assign req_ready = init_done && ((3'(pend) + 3'(count)) < 3'd3);
    assign acc       = req_valid && req_ready;
    assign push      = pend;
    assign rsp_valid = count != 2'd0;
    assign pop       = rsp_valid && rsp_ready;
    assign {head_err, rsp_dout} = fifo[rptr];
    assign rsp_err   = rsp_valid && head_err;

    always_comb begin
        state_nxt = state;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_wem   = req_wem;
        mem_addr  = req_addr;
        mem_din   = req_din;
        if (state == S_INIT) begin
            state_nxt = last ? S_RUN : S_INIT;
            // Gated by nreset so the zero-fill writes nothing while reset is held.
            mem_en    = nreset;
            mem_we    = nreset;
            mem_wem   = '1;
            mem_addr  = cnt;
            mem_din   = '0;
        end else begin
            mem_en = acc && in_range;
            mem_we = acc && in_range && req_write;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state     <= (INIT != 0) ? S_INIT : S_RUN;
            cnt       <= '0;
            init_done <= 1'b0;
            pend      <= 1'b0;
            pend_err  <= 1'b0;
            wptr      <= 2'd0;
            rptr      <= 2'd0;
            count     <= 2'd0;
        end else begin
            state     <= state_nxt;
            cnt       <= (state == S_INIT) ? cnt + AW'(1) : '0;
            init_done <= init_done || last || (state == S_RUN);
            pend      <= acc && !req_write;
            pend_err  <= !in_range;
            if (push) wptr <= (wptr == 2'd2) ? 2'd0 : wptr + 2'd1;
            if (pop)  rptr <= (rptr == 2'd2) ? 2'd0 : rptr + 2'd1;
            count     <= count + 2'(push) - 2'(pop);
        end
    end

    // Storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push) fifo[wptr] <= {pend_err, pend_err ? {DW{1'b0}} : mem_dout};
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!nreset) !(push && count == 2'd3));
endmodule

// File: tb/tb_memory_sp_ctrl.sv
// tb_memory_sp_ctrl: randomized self-checking bench for memory_sp_ctrl with a behavioural SRAM and reference model.
module tb_memory_sp_ctrl;
    localparam int DW = 104;
    localparam int D  = 24;
    localparam int AW = $clog2(D);

    typedef logic [DW:0] v_t;
    typedef struct {
        int            t;
        logic [DW-1:0] d;
        logic          e;
    } rsp_t;

    logic          clk = 1'b0;
    logic          nreset;
    logic          req_valid, req_ready, req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wem, req_din;
    logic          rsp_valid, rsp_ready, rsp_err, init_done;
    logic [DW-1:0] rsp_dout;
    logic          mem_en, mem_we;
    logic [DW-1:0] mem_wem, mem_din, mem_dout;
    logic [AW-1:0] mem_addr;

    logic [DW-1:0] ram     [32];
    logic [DW-1:0] ref_mem [D];
    rsp_t          q[$];
    int            cyc, vectors, errors;

    always #5 clk = ~clk;

    memory_sp_ctrl #(.DW(DW), .DEPTH(D), .INIT(1)) u_dut (
        .clk(clk), .nreset(nreset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wem(req_wem), .req_din(req_din),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dout(rsp_dout), .rsp_err(rsp_err),
        .init_done(init_done),
        .mem_en(mem_en), .mem_we(mem_we), .mem_wem(mem_wem), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_dout(mem_dout)
    );

    // Single-port SRAM: masked write, registered read data.
    always_ff @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= (ram[mem_addr] & ~mem_wem) | (mem_din & mem_wem);
            else        mem_dout      <= ram[mem_addr];
        end
    end

    task automatic chk(input string tag, input v_t got, input v_t exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd();
        return DW'({$urandom, $urandom, $urandom, $urandom});
    endfunction

    task automatic drive(input logic v, input logic w, input int a, input logic [DW-1:0] m, input logic [DW-1:0] dd);
        req_valid = v;
        req_write = w;
        req_addr  = AW'(a);
        req_wem   = m;
        req_din   = dd;
    endtask

    // One clock cycle: check outputs against the model mid-cycle, then advance the model.
    task automatic step(output logic acc);
        logic          inr, rdy, vis;
        logic [DW-1:0] d;
        @(negedge clk);
        inr = int'(req_addr) < D;
        rdy = q.size() < 3;
        acc = rdy && req_valid;
        vis = q.size() != 0 && q[0].t <= cyc;
        chk("req_ready", v_t'(req_ready), v_t'(rdy));
        chk("init_done", v_t'(init_done), v_t'(1'b1));
        chk("rsp_valid", v_t'(rsp_valid), v_t'(vis));
        if (vis) begin
            chk("rsp_dout", v_t'(rsp_dout), v_t'(q[0].d));
            chk("rsp_err", v_t'(rsp_err), v_t'(q[0].e));
        end
        chk("mem_en", v_t'(mem_en), v_t'(acc && inr));
        chk("mem_we", v_t'(mem_we), v_t'(acc && inr && req_write));
        if (acc && inr) chk("mem_addr", v_t'(mem_addr), v_t'(req_addr));
        if (acc && inr && req_write) begin
            chk("mem_wem", v_t'(mem_wem), v_t'(req_wem));
            chk("mem_din", v_t'(mem_din), v_t'(req_din));
            ref_mem[req_addr] = (ref_mem[req_addr] & ~req_wem) | (req_din & req_wem);
        end
        if (acc && !req_write) begin
            d = '0;
            if (inr) d = ref_mem[req_addr];
            q.push_back('{cyc + 2, d, !inr});
        end
        if (vis && rsp_ready) void'(q.pop_front());
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        logic a;
        drive(1'b0, 1'b0, 0, '0, '0);
        for (int i = 0; i < n; i++) step(a);
    endtask

    task automatic do_reset();
        nreset = 1'b0;
        drive(1'b0, 1'b0, 0, '0, '0);
        #2;
        chk("rst_rsp_valid", v_t'(rsp_valid), v_t'(1'b0));
        chk("rst_req_ready", v_t'(req_ready), v_t'(1'b0));
        chk("rst_rsp_err", v_t'(rsp_err), v_t'(1'b0));
        chk("rst_init_done", v_t'(init_done), v_t'(1'b0));
        chk("rst_mem_en", v_t'(mem_en), v_t'(1'b0));
        chk("rst_mem_we", v_t'(mem_we), v_t'(1'b0));
        repeat (2) @(posedge clk);
        #1;
        nreset = 1'b1;
        q.delete();
        for (int i = 0; i < D; i++) ref_mem[i] = '0;
        for (int c = 0; c < D; c++) begin
            @(negedge clk);
            chk("init_mem_en", v_t'(mem_en), v_t'(1'b1));
            chk("init_mem_we", v_t'(mem_we), v_t'(1'b1));
            chk("init_mem_addr", v_t'(mem_addr), v_t'(c));
            chk("init_mem_din", v_t'(mem_din), v_t'(0));
            chk("init_mem_wem", v_t'(mem_wem), v_t'({DW{1'b1}}));
            chk("init_req_ready", v_t'(req_ready), v_t'(1'b0));
            chk("init_done_low", v_t'(init_done), v_t'(1'b0));
            @(posedge clk);
            #1;
            cyc++;
        end
        @(negedge clk);
        chk("init_done_high", v_t'(init_done), v_t'(1'b1));
        chk("init_req_ready_high", v_t'(req_ready), v_t'(1'b1));
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        logic a;
        int   n, i;
        vectors   = 0;
        errors    = 0;
        cyc       = 0;
        nreset    = 1'b1;
        rsp_ready = 1'b1;
        mem_dout  = '0;
        for (int k = 0; k < 32; k++) ram[k] = rnd();
        drive(1'b0, 1'b0, 0, '0, '0);
        #1;
        do_reset();

        // Every word reads back as zero after the fill.
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 1'b0, $urandom_range(D - 1), '0, '0);
            step(a);
        end
        idle(4);

        // Write then read the same address on the next cycle.
        drive(1'b1, 1'b1, 5, {DW{1'b1}}, DW'(32'hA5));
        step(a);
        drive(1'b1, 1'b0, 5, '0, '0);
        step(a);
        idle(4);

        // Partial-mask write.
        drive(1'b1, 1'b1, 7, {DW{1'b1}}, DW'(32'hFFFF));
        step(a);
        drive(1'b1, 1'b1, 7, DW'(32'hFF), DW'(32'h1234));
        step(a);
        drive(1'b1, 1'b0, 7, '0, '0);
        step(a);
        idle(4);

        // Backpressure: only three reads get credit while rsp_ready is low.
        rsp_ready = 1'b0;
        n = 0;
        i = 0;
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 1'b0, i, '0, '0);
            step(a);
            if (a) begin
                i++;
                n++;
            end
        end
        chk("bp_accepts", v_t'(n), v_t'(3));
        rsp_ready = 1'b1;
        for (int k = 0; k < 30 && i < 6; k++) begin
            drive(1'b1, 1'b0, i, '0, '0);
            step(a);
            if (a) i++;
        end
        chk("bp_total", v_t'(i), v_t'(6));
        idle(4);

        // Back-to-back reads at full rate.
        n = 0;
        for (int k = 0; k < 16; k++) begin
            drive(1'b1, 1'b0, $urandom_range(D - 1), '0, '0);
            step(a);
            n += int'(a);
        end
        chk("b2b_accepts", v_t'(n), v_t'(16));
        idle(4);

        // Out-of-range write is dropped, read reports an error.
        drive(1'b1, 1'b1, 30, {DW{1'b1}}, rnd());
        step(a);
        drive(1'b1, 1'b0, 30, '0, '0);
        step(a);
        idle(4);

        // Random traffic.
        for (int k = 0; k < 400; k++) begin
            drive(($urandom % 4) != 0, $urandom % 2, $urandom_range(31),
                  ($urandom % 2) ? {DW{1'b1}} : rnd(), rnd());
            rsp_ready = ($urandom % 4) != 0;
            step(a);
        end
        rsp_ready = 1'b1;
        idle(6);

        // Reset with two responses buffered.
        rsp_ready = 1'b0;
        drive(1'b1, 1'b0, 1, '0, '0);
        step(a);
        drive(1'b1, 1'b0, 2, '0, '0);
        step(a);
        idle(3);
        chk("buffered_before_reset", v_t'(q.size()), v_t'(2));
        do_reset();
        rsp_ready = 1'b1;
        idle(5);
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, $urandom % 2, $urandom_range(31), rnd(), rnd());
            step(a);
        end
        idle(5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/memory_sp_ctrl.md
Name: memory_sp_ctrl

Overview:
- Initiator-side controller for a single-port synchronous SRAM: drives en/we/wem/addr/din and receives dout.
- Converts a valid/ready request channel into memory accesses and returns read data on a valid/ready response channel through a 3-entry response FIFO, so `rsp_ready` backpressure never loses data.
- Optionally zero-fills the whole array after reset before accepting traffic.
- Sits between fabric/DMA logic and the single-port memory wrapper.

Parameters:
- DW, 104, data width and write-enable mask width.
- DEPTH, 32, memory depth in words.
- AW, $clog2(DEPTH), address width.
- INIT, 1, 1 = zero-fill all DEPTH words after reset; 0 = skip.

Ports:
- clk  input  1  clock
- nreset  input  1  asynchronous active-low reset
- req_valid  input  1  request valid
- req_ready  output  1  request accepted when valid&ready
- req_write  input  1  1 = write, 0 = read
- req_addr  input  AW  word address
- req_wem  input  DW  per-bit write enable
- req_din  input  DW  write data
- rsp_valid  output  1  read data valid
- rsp_ready  input  1  consumer accepts read data
- rsp_dout  output  DW  read data
- rsp_err  output  1  response is for an out-of-range address; rsp_dout = 0
- init_done  output  1  zero-fill complete; high until next reset
- mem_en  output  1  memory access
- mem_we  output  1  memory write
- mem_wem  output  DW  memory write mask
- mem_addr  output  AW  memory address
- mem_din  output  DW  memory write data
- mem_dout  input  DW  memory read data, valid the cycle after a read access

Behaviour:
- Clock and reset:
  - Single clock domain.
  - nreset low asynchronously clears: state, init counter, pending flag, FIFO pointers and count.
  - Output values during reset: req_ready=0, rsp_valid=0, rsp_err=0, init_done=0, mem_en=0, mem_we=0.
- FSM states: INIT, RUN. Reset enters INIT if INIT=1, else RUN.
- INIT state:
  - Counter c runs 0..DEPTH-1, one word per cycle.
  - Each cycle: mem_en=1, mem_we=1, mem_wem=all ones, mem_din=0, mem_addr=c. req_ready=0.
  - After the c=DEPTH-1 cycle, go to RUN and set init_done=1. init_done is registered and rises in the first RUN cycle.
  - The init sequence is DEPTH cycles long.
- INIT=0: init_done=1 from the first clock edge after reset release.
- RUN state, request acceptance:
  - req_ready = (pending + fifo_count < 3). This is registered state only; there is no combinational path from rsp_ready or req_valid.
  - On accept, the memory outputs are combinational from the request in the same cycle: mem_en=1, mem_we=req_write, mem_addr, mem_wem, mem_din.
  - No accept: mem_en=0, mem_we=0.
- Out-of-range address (req_addr >= DEPTH, only possible for non-power-of-two DEPTH):
  - The request is accepted but mem_en is held 0.
  - A write is dropped.
  - A read still produces a response with rsp_err=1 and rsp_dout=0.
- Writes produce no response.
- Read timing:
  - An accepted read sets the pending flag (with its err bit) at the next edge.
  - While pending, mem_dout is pushed into the FIFO at the end of that cycle.
  - A read accepted in cycle N gives rsp_valid=1 in cycle N+2 at the earliest.
- Response FIFO:
  - 3 entries, each DW+1 bits.
  - rsp_valid = count != 0; rsp_dout and rsp_err come from the head entry.
  - Pop on rsp_valid & rsp_ready.
  - Push and pop in the same cycle are legal and leave count unchanged.
  - Credit rule guarantees no overflow. A push when full is a design error; flag it with an assertion in simulation.
- Throughput:
  - With rsp_ready held high, back-to-back reads sustain 1 per cycle (steady state pending=1, count=1).
  - With rsp_ready low, at most 3 reads are accepted, then req_ready=0 until a pop.
- Ordering: responses return in request order. A read in the cycle after a write to the same address returns the new data, since the memory writes on that edge.
- Reset mid-operation: in-flight reads and buffered responses are discarded; INIT reruns if enabled.

Test Plan:
- Reset release with INIT=1, DEPTH=32: 32 consecutive cycles of mem_en=1, mem_we=1, addr 0..31, din=0; req_ready=0 throughout; init_done=1 and req_ready=1 in cycle 32. Every subsequent read returns 0.
- Write addr 5 = 0xA5 (wem all ones), then read addr 5 in the next cycle: rsp_valid rises 2 cycles after the read is accepted, rsp_dout=0xA5, rsp_err=0.
- Partial write: wem=0xFF, din=0x1234 on a word holding 0xFFFF; read back gives 0xFF34.
- rsp_ready=0 with reads to addr 0..5 offered continuously: exactly 3 accepted, req_ready=0. Then rsp_ready=1: data for addr 0,1,2 returned in order, and addr 3..5 follow without loss.
- rsp_ready=1 with 16 back-to-back reads: req_ready never drops, 16 responses on 16 consecutive cycles.
- DEPTH=24: read addr 30 gives rsp_err=1, rsp_dout=0, mem_en=0. Write addr 30 leaves memory unchanged.
- Assert nreset with 2 responses buffered: rsp_valid=0 immediately, no stale response after release, INIT sequence repeats.
